// File: rtl/inorder_queue_ctrl_pkg.sv
// inorder_queue_ctrl_pkg: shared sizing defaults, pointer type and full/empty helpers for inorder_queue_ctrl.
package inorder_queue_ctrl_pkg;
   localparam int DEF_QUEUE_SIZE     = 8;
   localparam int DEF_QUEUE_SIZE_LOG = 3;
   typedef logic [DEF_QUEUE_SIZE_LOG:0] qptr_t;
   // Same index with opposite wrap bits means the tail has lapped the head.
   function automatic logic ptr_full(input qptr_t e, input qptr_t d);
      return (e[DEF_QUEUE_SIZE_LOG-1:0] == d[DEF_QUEUE_SIZE_LOG-1:0]) && (e[DEF_QUEUE_SIZE_LOG] != d[DEF_QUEUE_SIZE_LOG]);
   endfunction
   function automatic logic ptr_empty(input qptr_t e, input qptr_t d);
      return e == d;
   endfunction
endpackage

// File: rtl/inorder_queue_ctrl_qptr_onehot_dec.sv
// qptr_onehot_dec: queue index to onehot entry select.
module qptr_onehot_dec #(
   parameter int SIZE = 8,
   parameter int LOG  = 3
) (
   input  logic [LOG-1:0]  idx,
   output logic [SIZE-1:0] oh
);
   assign oh = SIZE'(1) << idx;
endmodule

// File: rtl/inorder_queue_ctrl.sv
// inorder_queue_ctrl: head/tail pointer, occupancy and flush-rollback control for an in-order circular queue.
// Define QCTRL_PERF_EN to add saturating full-cycle and flush-event counters.
module inorder_queue_ctrl
   import inorder_queue_ctrl_pkg::*;
#(
   parameter int QUEUE_SIZE     = DEF_QUEUE_SIZE,
   parameter int QUEUE_SIZE_LOG = DEF_QUEUE_SIZE_LOG
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    enq_valid,
   output logic                    enq_ready,
   input  logic                    deq_ready,
   output logic                    deq_valid,
   input  logic                    flush_valid,
   input  logic [QUEUE_SIZE_LOG:0] flush_cnt,
   output logic [QUEUE_SIZE_LOG:0] enq_ptr,
   output logic [QUEUE_SIZE_LOG:0] deq_ptr,
   output logic [QUEUE_SIZE-1:0]   enq_ptr_oh,
   output logic [QUEUE_SIZE-1:0]   deq_ptr_oh,
   output logic [QUEUE_SIZE_LOG:0] count,
   output logic                    full,
   output logic                    empty
`ifdef QCTRL_PERF_EN
   ,
   output logic [31:0]             perf_full_cycles,
   output logic [31:0]             perf_flush_events
`endif
);
   localparam int PW = QUEUE_SIZE_LOG + 1;
   generate
      if (QUEUE_SIZE != 2**QUEUE_SIZE_LOG || $bits(qptr_t) != PW) begin : g_bad_cfg
         $error("inorder_queue_ctrl: QUEUE_SIZE must equal 2**QUEUE_SIZE_LOG and match qptr_t");
      end
   endgenerate
   logic enq_fire;
   logic deq_fire;
   assign full      = ptr_full(enq_ptr, deq_ptr);
   assign empty     = ptr_empty(enq_ptr, deq_ptr);
   assign count     = enq_ptr - deq_ptr;
   assign enq_ready = ~full & ~flush_valid;
   assign deq_valid = ~empty;
   assign enq_fire  = enq_valid & enq_ready;
   assign deq_fire  = deq_ready & deq_valid;
   // Flush owns the tail outright; the head keeps retiring in the same cycle.
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         enq_ptr <= '0;
         deq_ptr <= '0;
      end else begin
         enq_ptr <= flush_valid ? enq_ptr - flush_cnt : enq_ptr + PW'(enq_fire);
         deq_ptr <= deq_ptr + PW'(deq_fire);
      end
   qptr_onehot_dec #(.SIZE(QUEUE_SIZE), .LOG(QUEUE_SIZE_LOG)) u_enq_dec (
      .idx(enq_ptr[QUEUE_SIZE_LOG-1:0]),
      .oh (enq_ptr_oh)
   );
   qptr_onehot_dec #(.SIZE(QUEUE_SIZE), .LOG(QUEUE_SIZE_LOG)) u_deq_dec (
      .idx(deq_ptr[QUEUE_SIZE_LOG-1:0]),
      .oh (deq_ptr_oh)
   );
   // A flush may only remove entries that are not retiring this cycle.
   always @(posedge clock)
      if (reset_n && flush_valid)
         assert (flush_cnt <= count - PW'(deq_fire))
         else $error("inorder_queue_ctrl: flush_cnt %0d exceeds removable entries", flush_cnt);
`ifdef QCTRL_PERF_EN
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         perf_full_cycles  <= '0;
         perf_flush_events <= '0;
      end else begin
         if (full && perf_full_cycles != '1) perf_full_cycles <= perf_full_cycles + 32'd1;
         if (flush_valid && perf_flush_events != '1) perf_flush_events <= perf_flush_events + 32'd1;
      end
`endif
endmodule

// File: tb/tb_inorder_queue_ctrl.sv
// tb_inorder_queue_ctrl: scoreboard bench for inorder_queue_ctrl at QUEUE_SIZE=8.
module tb_inorder_queue_ctrl;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       enq_valid = 1'b0;
   logic       deq_ready = 1'b0;
   logic       flush_valid = 1'b0;
   logic [3:0] flush_cnt = 4'd0;
   logic       enq_ready, deq_valid, full, empty;
   logic [3:0] enq_ptr, deq_ptr, count;
   logic [7:0] enq_ptr_oh, deq_ptr_oh;
`ifdef QCTRL_PERF_EN
   logic [31:0] perf_full_cycles, perf_flush_events;
`endif
   int errors = 0;
   int checks = 0;
   logic [3:0] sb[$];
   logic [3:0] m_enq = 4'd0;

   always #5 clock = ~clock;

   inorder_queue_ctrl dut (
      .clock(clock), .reset_n(reset_n),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .deq_ready(deq_ready), .deq_valid(deq_valid),
      .flush_valid(flush_valid), .flush_cnt(flush_cnt),
      .enq_ptr(enq_ptr), .deq_ptr(deq_ptr),
      .enq_ptr_oh(enq_ptr_oh), .deq_ptr_oh(deq_ptr_oh),
      .count(count), .full(full), .empty(empty)
`ifdef QCTRL_PERF_EN
      , .perf_full_cycles(perf_full_cycles), .perf_flush_events(perf_flush_events)
`endif
   );

   // Advance one clock; the scoreboard holds the slot pointer of every live entry, oldest first.
   task automatic cycle();
      logic ef, df;
      ef = enq_valid && sb.size() < 8 && !flush_valid;
      df = deq_ready && sb.size() > 0;
      if (df) void'(sb.pop_front());
      if (flush_valid) begin
         for (int i = 0; i < int'(flush_cnt); i++) void'(sb.pop_back());
         m_enq = m_enq - flush_cnt;
      end else if (ef) begin
         sb.push_back(m_enq);
         m_enq = m_enq + 4'd1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] got;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      got = {enq_ptr, deq_ptr, count, full, empty, enq_ready, deq_valid, enq_ptr_oh, deq_ptr_oh};
      checks++;
      if (got !== {4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01}) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", got, {4'd0, 4'd0, 4'd0, 4'b0110, 8'h01, 8'h01});
      end
      reset_n = 1'b1;
      cycle();
      checks++;
      if (count !== 4'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: count=%0d empty=%b want 0/1", count, empty);
      end
   endtask

   task automatic test_fill();
      enq_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (enq_ptr !== m_enq || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_ptr[%0d]: enq_ptr=%0d ready=%b want %0d/1", i, enq_ptr, enq_ready, m_enq);
         end
         cycle();
      end
      checks++;
      if ({full, count, enq_ready, enq_ptr, enq_ptr_oh} !== {1'b1, 4'd8, 1'b0, 4'b1000, 8'h01}) begin
         errors++;
         $display("FAIL fill_full: full=%b count=%0d ready=%b enq_ptr=%b oh=%h want 1/8/0/1000/01",
                  full, count, enq_ready, enq_ptr, enq_ptr_oh);
      end
      cycle();
      checks++;
      if (count !== 4'd8 || enq_ptr !== 4'b1000) begin
         errors++;
         $display("FAIL fill_overflow: count=%0d enq_ptr=%b want 8/1000", count, enq_ptr);
      end
      enq_valid = 1'b0;
   endtask

   task automatic test_drain();
      logic [3:0] exp;
      logic [7:0] exp_oh;
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = sb[0];
         exp_oh = 8'd1 << exp[2:0];
         checks++;
         if (deq_ptr !== exp || deq_ptr_oh !== exp_oh || deq_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_head[%0d]: deq_ptr=%0d oh=%h valid=%b want %0d/%h/1", i, deq_ptr, deq_ptr_oh, deq_valid, exp, exp_oh);
         end
         cycle();
         enq_valid = 1'b0;
         checks++;
         if (count !== 4'(sb.size())) begin
            errors++;
            $display("FAIL drain_count[%0d]: count=%0d want %0d", i, count, sb.size());
         end
      end
      checks++;
      if ({empty, deq_valid, deq_ptr} !== {1'b1, 1'b0, 4'b1000}) begin
         errors++;
         $display("FAIL drain_empty: empty=%b valid=%b deq_ptr=%b want 1/0/1000", empty, deq_valid, deq_ptr);
      end
      cycle();
      checks++;
      if (deq_ptr !== 4'b1000 || deq_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_underflow: deq_ptr=%b valid=%b want 1000/0", deq_ptr, deq_valid);
      end
      deq_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp;
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      cycle();
      deq_ready = 1'b0;
      checks++;
      if (count !== 4'd1) begin
         errors++;
         $display("FAIL b2b_empty_enq: count=%0d want 1", count);
      end
      repeat (3) cycle();
      deq_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         exp = sb[0];
         checks++;
         if (count !== 4'd4 || deq_ptr !== exp) begin
            errors++;
            $display("FAIL b2b_steady[%0d]: count=%0d deq_ptr=%0d want 4/%0d", i, count, deq_ptr, exp);
         end
         cycle();
      end
      checks++;
      if (enq_ptr !== 4'b0000 || deq_ptr !== 4'b1100 || count !== 4'd4) begin
         errors++;
         $display("FAIL b2b_wrap: enq_ptr=%b deq_ptr=%b count=%0d want 0000/1100/4", enq_ptr, deq_ptr, count);
      end
      enq_valid = 1'b0;
      repeat (4) cycle();
      deq_ready = 1'b0;
      checks++;
      if (empty !== 1'b1 || deq_ptr !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_drain: empty=%b deq_ptr=%b want 1/0000", empty, deq_ptr);
      end
   endtask

   task automatic test_flush();
      enq_valid = 1'b1;
      repeat (5) cycle();
      flush_valid = 1'b1;
      flush_cnt = 4'd3;
      #1;
      checks++;
      if (enq_ready !== 1'b0 || count !== 4'd5) begin
         errors++;
         $display("FAIL flush_block: enq_ready=%b count=%0d want 0/5", enq_ready, count);
      end
      cycle();
      checks++;
      if (count !== 4'd2 || enq_ptr !== 4'd2) begin
         errors++;
         $display("FAIL flush_rollback: count=%0d enq_ptr=%0d want 2/2", count, enq_ptr);
      end
      flush_cnt = 4'd0;
      #1;
      checks++;
      if (enq_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_zero_block: enq_ready=%b want 0", enq_ready);
      end
      cycle();
      flush_valid = 1'b0;
      checks++;
      if (count !== 4'd2 || enq_ptr !== m_enq) begin
         errors++;
         $display("FAIL flush_zero: count=%0d enq_ptr=%0d want 2/%0d", count, enq_ptr, m_enq);
      end
      cycle();
      enq_valid = 1'b0;
      flush_valid = 1'b1;
      flush_cnt = 4'd2;
      deq_ready = 1'b1;
      cycle();
      flush_valid = 1'b0;
      deq_ready = 1'b0;
      checks++;
      if (count !== 4'd0 || empty !== 1'b1 || enq_ptr !== 4'd1 || deq_ptr !== 4'd1) begin
         errors++;
         $display("FAIL flush_with_deq: count=%0d empty=%b enq=%0d deq=%0d want 0/1/1/1", count, empty, enq_ptr, deq_ptr);
      end
      enq_valid = 1'b1;
      repeat (8) cycle();
      enq_valid = 1'b0;
      flush_valid = 1'b1;
      flush_cnt = 4'd8;
      cycle();
      flush_valid = 1'b0;
      checks++;
      if (empty !== 1'b1 || enq_ptr !== deq_ptr || enq_ptr !== 4'd1 || deq_ptr !== m_enq) begin
         errors++;
         $display("FAIL flush_all: empty=%b enq=%b deq=%b want 1/0001/0001", empty, enq_ptr, deq_ptr);
      end
   endtask

   task automatic test_async_reset();
      enq_valid = 1'b1;
      repeat (6) cycle();
      enq_valid = 1'b0;
      checks++;
      if (count !== 4'd6) begin
         errors++;
         $display("FAIL areset_pre: count=%0d want 6", count);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({enq_ptr, deq_ptr, count, full, empty, enq_ready, deq_valid, enq_ptr_oh, deq_ptr_oh}
          !== {4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01}) begin
         errors++;
         $display("FAIL areset_clear: enq=%0d deq=%0d count=%0d empty=%b oh=%h/%h", enq_ptr, deq_ptr, count, empty, enq_ptr_oh, deq_ptr_oh);
      end
`ifdef QCTRL_PERF_EN
      checks++;
      if (perf_full_cycles !== 32'd0 || perf_flush_events !== 32'd0) begin
         errors++;
         $display("FAIL areset_perf: full=%0d flush=%0d want 0/0", perf_full_cycles, perf_flush_events);
      end
`endif
      sb.delete();
      m_enq = 4'd0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      enq_valid = 1'b1;
      cycle();
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      checks++;
      if (deq_ptr !== sb[0] || count !== 4'd1) begin
         errors++;
         $display("FAIL areset_resume: deq_ptr=%0d count=%0d want %0d/1", deq_ptr, count, sb[0]);
      end
      cycle();
      deq_ready = 1'b0;
      checks++;
      if (empty !== 1'b1 || deq_ptr !== 4'd1) begin
         errors++;
         $display("FAIL areset_drain: empty=%b deq_ptr=%0d want 1/1", empty, deq_ptr);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
